sccb_responder: RTL and testbench
=================================

Name: sccb_responder

Overview:
- SCCB slave (camera-side register interface), the responder end of the bus driven by our SCCB initiator.
- Stands in for the sensor register bank, for bring-up loopback on the board and for simulating the configuration path without the camera fitted.
- Decodes 3-phase writes (ID, sub-address, data) and 2-phase write + 2-phase read sequences.
- Holds an internal register bank and exposes write strobes plus a 32-bit debug word for the seven-segment display.

Parameters:
- DEV_ID, 8'h42, write device ID; the read ID is DEV_ID|1, and only bits [7:1] are compared.
- ADDR_W, 8, sub-address width; register bank depth is 2**ADDR_W bytes.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (minimum 2).

Ports:
- clk  in  1  system clock, at least 16x the SCL rate; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL from pad.
- sda_in  in  1  raw SDA from pad.
- sda_oe  out  1  1 = pull SDA low; 0 = release. The top level builds the open-drain inout from it.
- wr_stb  out  1  one-cycle pulse when a register write commits.
- wr_addr  out  ADDR_W  sub-address of the committed write.
- wr_data  out  8  data of the committed write.
- rd_stb  out  1  one-cycle pulse when a read byte is loaded for shifting.
- busy  out  1  high from a START with matching ID until STOP.
- debug_out  out  32  {last_sub[7:0], last_data[7:0], write_count[15:0]}; last_sub is zero-extended or truncated to 8 bits.

Behaviour:
- Reset values: sda_oe=0, wr_stb=0, rd_stb=0, busy=0, wr_addr=0, wr_data=0, debug_out=0. Register bank is all 8'h00, sub_addr=0, state=IDLE.
- Reset mid-transaction releases SDA on the next clk and discards any partial byte.
- Input path: scl_in/sda_in pass through SYNC_STAGES flops, then edge detect. All bus events lag the pins by SYNC_STAGES+1 clk.
- START = synchronized SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- START in any state, including a repeated START, jumps to ID with bit_cnt=0. STOP in any state goes to IDLE and releases SDA.
- Bits are sampled on the synchronized SCL rising edge, MSB first; bit_cnt runs 0..7 and then the 9th (X) bit.
- SDA is changed only one clk after the synchronized SCL falling edge, never while SCL is high.
- State IDLE: wait for START.
- State ID: shift 8 bits.
  - bits [7:1] != DEV_ID[7:1] -> IGNORE (SDA released until STOP or START).
  - match -> ID_X and busy=1; bit0 selects the path (0 = write, 1 = read).
- State ID_X: X bit.
  - write path -> SUB.
  - read path -> RD_LOAD.
- State SUB: shift 8 bits into sub_addr[ADDR_W-1:0]. Upper bits are dropped when ADDR_W<8; zero-filled when ADDR_W>8. Then SUB_X.
- State SUB_X -> WDATA.
  - A STOP here ends a 2-phase write; sub_addr is retained for a following read.
- State WDATA: shift 8 bits, then WDATA_X. On entry to WDATA_X:
  - reg[sub_addr] <= byte.
  - wr_stb pulses for exactly 1 clk with wr_addr/wr_data held until the next commit.
  - write_count increments and wraps at 16'hFFFF -> 0.
  - last_sub and last_data update.
- State WDATA_X -> IGNORE. Extra data bytes are not written.
- State RD_LOAD: after the ID X bit completes (SCL falling edge), load shift_reg=reg[sub_addr] and pulse rd_stb. Then RDATA.
- State RDATA: on each SCL falling edge drive sda_oe = ~shift_reg[7] and shift left; 8 bits total.
  - After the 8th bit's SCL falling edge, sda_oe=0 and go to RD_NA.
  - sub_addr is not incremented.
- State RD_NA: master NA/X bit is ignored -> IGNORE until STOP.
- STOP during WDATA before 8 bits: no write, no strobe.
- STOP mid-read: SDA released and no further strobes.
- A glitch shorter than 1 clk on the raw pins is not filtered beyond the synchronizer.

Optional Feature:
- Macro SCCB_ACK_DRIVE_EN.
- Defined: the responder drives sda_oe=1 for the whole X bit after the ID (match only), sub-address and write-data bytes. The drive runs from one clk after the SCL falling edge that ends bit 8 until one clk after the next SCL falling edge, giving I2C-style ACK.
- Not defined: SDA stays released during every X bit (pure SCCB don't-care); all other behaviour is identical.

Test Plan:
- 3-phase write ID 0x42, sub 0x12, data 0x80 -> one wr_stb with wr_addr=0x12, wr_data=0x80. debug_out=32'h12800001.
- 2-phase write ID 0x42, sub 0x12, STOP; then ID 0x43 read -> rd_stb once and SDA bits 1,0,0,0,0,0,0,0 on 8 SCL highs. SDA is released in the NA slot.
- Write with ID 0x60 -> no wr_stb, busy stays 0, sda_oe=0 throughout, write_count unchanged.
- STOP after 5 data bits, then START -> no wr_stb, state back to ID. The next full write 0x42/0x3A/0x04 commits normally.
- rst asserted while sda_oe=1 during a read -> sda_oe=0 one clk later. All outputs reset; reg[0x12] reads back 0x00.
- With SCCB_ACK_DRIVE_EN: 3-phase write -> sda_oe=1 during all three X bits. Without it -> sda_oe=0 in every X bit.

Source files
------------

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB slave with an internal register bank, write/read strobes and a debug word.
// Define SCCB_ACK_DRIVE_EN to pull SDA low during the X bits (I2C-style ACK).
module sccb_responder #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         ADDR_W      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_stb,
    output logic              busy,
    output logic [31:0]       debug_out
);
`ifdef SCCB_ACK_DRIVE_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif
    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_X, S_SUB, S_SUB_X, S_WDATA, S_WDATA_X,
        S_RD_LOAD, S_RDATA, S_RD_NA, S_IGNORE
    } state_t;
    state_t r_state, w_next;
    logic [SYNC_STAGES-1:0] r_scl_s, r_sda_s;
    logic r_scl_d, r_sda_d, r_x_seen, r_rd, r_sda_oe, r_wr_stb, r_rd_stb, r_busy;
    logic [7:0] r_shift, r_wr_data, r_last_sub, r_last_data;
    logic [2:0] r_cnt;
    logic [15:0] r_wcount;
    logic [ADDR_W-1:0] r_sub, r_wr_addr;
    logic [7:0] r_mem [2**ADDR_W];
    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_bit_done, w_x_done, w_id_match, w_shift_state, w_x_state;
    logic [7:0] w_byte, w_rd_byte;
    assign w_scl         = r_scl_s[SYNC_STAGES-1];
    assign w_sda         = r_sda_s[SYNC_STAGES-1];
    assign w_scl_rise    = w_scl & ~r_scl_d;
    assign w_scl_fall    = ~w_scl & r_scl_d;
    assign w_start       = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop        = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte        = {r_shift[6:0], w_sda};
    assign w_rd_byte     = r_mem[r_sub];
    assign w_bit_done    = w_scl_rise && r_cnt == 3'd7;
    assign w_x_done      = w_scl_fall && r_x_seen;
    assign w_id_match    = r_shift[6:0] == DEV_ID[7:1];
    assign w_shift_state = r_state inside {S_ID, S_SUB, S_WDATA};
    assign w_x_state     = r_state inside {S_ID_X, S_SUB_X, S_WDATA_X};
    always_comb begin
        w_next = r_state;
        if (w_stop)
            w_next = S_IDLE;
        else if (w_start)
            w_next = S_ID;
        else
            case (r_state)
                S_ID:      if (w_bit_done) w_next = w_id_match ? S_ID_X : S_IGNORE;
                S_ID_X:    if (w_x_done) w_next = r_rd ? S_RD_LOAD : S_SUB;
                S_SUB:     if (w_bit_done) w_next = S_SUB_X;
                S_SUB_X:   if (w_x_done) w_next = S_WDATA;
                S_WDATA:   if (w_bit_done) w_next = S_WDATA_X;
                S_WDATA_X: if (w_x_done) w_next = S_IGNORE;
                S_RD_LOAD: w_next = S_RDATA;
                S_RDATA:   if (w_scl_fall && r_cnt == 3'd7) w_next = S_RD_NA;
                S_RD_NA:   w_next = S_IGNORE;
                default:   w_next = r_state;
            endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s     <= '1;
            r_sda_s     <= '1;
            r_scl_d     <= 1'b1;
            r_sda_d     <= 1'b1;
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_x_seen    <= 1'b0;
            r_rd        <= 1'b0;
            r_sub       <= '0;
            r_sda_oe    <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_rd_stb    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_last_sub  <= '0;
            r_last_data <= '0;
            r_wcount    <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
        end else begin
            r_scl_s  <= {r_scl_s[SYNC_STAGES-2:0], scl_in};
            r_sda_s  <= {r_sda_s[SYNC_STAGES-2:0], sda_in};
            r_scl_d  <= w_scl;
            r_sda_d  <= w_sda;
            r_state  <= w_next;
            r_wr_stb <= 1'b0;
            r_rd_stb <= 1'b0;
            if (w_stop || w_start) begin
                r_cnt    <= '0;
                r_sda_oe <= 1'b0;
                if (w_stop) r_busy <= 1'b0;
            end else if (w_shift_state && w_scl_rise) begin
                r_shift  <= w_byte;
                r_cnt    <= r_cnt + 3'd1;
                r_x_seen <= 1'b0;
                if (w_bit_done && r_state == S_ID && w_id_match) begin
                    r_busy <= 1'b1;
                    r_rd   <= w_sda;
                end
                if (w_bit_done && r_state == S_SUB) r_sub <= ADDR_W'(w_byte);
                if (w_bit_done && r_state == S_WDATA) begin
                    r_mem[r_sub] <= w_byte;
                    r_wr_stb     <= 1'b1;
                    r_wr_addr    <= r_sub;
                    r_wr_data    <= w_byte;
                    r_wcount     <= r_wcount + 16'd1;
                    r_last_sub   <= 8'(r_sub);
                    r_last_data  <= w_byte;
                end
            end else if (w_x_state) begin
                if (w_scl_rise) r_x_seen <= 1'b1;
                if (w_scl_fall) r_sda_oe <= ACK & ~r_x_seen;
                // Read byte is loaded and its MSB driven on the fall that closes the ID X bit
                if (w_x_done && r_state == S_ID_X && r_rd) begin
                    r_shift  <= {w_rd_byte[6:0], 1'b0};
                    r_sda_oe <= ~w_rd_byte[7];
                    r_rd_stb <= 1'b1;
                end
            end else if (r_state == S_RDATA && w_scl_fall) begin
                r_sda_oe <= (r_cnt != 3'd7) & ~r_shift[7];
                r_shift  <= r_shift << 1;
                r_cnt    <= r_cnt + 3'd1;
            end
        end
    end
    assign sda_oe    = r_sda_oe;
    assign wr_stb    = r_wr_stb;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_stb    = r_rd_stb;
    assign busy      = r_busy;
    assign debug_out = {r_last_sub, r_last_data, r_wcount};
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bus-master model driving sccb_responder with a write-strobe scoreboard.
module tb_sccb_responder;
    localparam int Q = 4;
`ifdef SCCB_ACK_DRIVE_EN
    localparam logic EXP_ACK = 1'b1;
`else
    localparam logic EXP_ACK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sda_in, sda_oe, wr_stb, rd_stb, busy;
    logic [7:0] wr_addr, wr_data;
    logic [31:0] debug_out;
    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt = 0;
    logic seen_oe = 1'b0;
    logic seen_busy = 1'b0;
    logic [15:0] exp_q[$];
    logic [7:0] model [256];
    assign sda_in = m_sda & ~sda_oe;
    sccb_responder dut (
        .clk(clk), .rst(rst), .scl_in(m_scl), .sda_in(sda_in), .sda_oe(sda_oe),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .rd_stb(rd_stb),
        .busy(busy), .debug_out(debug_out)
    );
    always #5 clk = ~clk;
    // Every cycle passes through here, so strobes are scored as they appear
    task automatic tick;
        logic [15:0] e;
        @(negedge clk);
        if (sda_oe) seen_oe = 1'b1;
        if (busy) seen_busy = 1'b1;
        if (rd_stb) rd_cnt++;
        if (wr_stb) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL wr_stb_unexpected: got addr=%h data=%h, required no strobe", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    n_errors++;
                    $display("FAIL wr_commit: got %h, required %h", {wr_addr, wr_data}, e);
                end
            end
        end
    endtask
    task automatic wait_q(input int n);
        repeat (n) tick();
    endtask
    task automatic bus_start;
        m_sda = 1'b1; m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask
    task automatic bus_stop;
        m_sda = 1'b0; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        m_sda = 1'b1; wait_q(2*Q);
    endtask
    task automatic send_bit(input logic b, output logic line, output logic oe);
        m_sda = b; wait_q(Q);
        m_scl = 1'b1; wait_q(Q);
        line = sda_in;
        oe = sda_oe;
        wait_q(Q);
        m_scl = 1'b0; wait_q(Q);
    endtask
    task automatic send_byte(input logic [7:0] v, output logic x_oe);
        logic l, o;
        for (int i = 7; i >= 0; i--) send_bit(v[i], l, o);
        send_bit(1'b1, l, x_oe);
    endtask
    task automatic read_byte(output logic [7:0] v, output logic na_oe);
        logic l, o;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, l, o);
            v[i] = l;
        end
        send_bit(1'b1, l, na_oe);
    endtask
    task automatic test_reset;
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        wait_q(4);
        rst = 1'b0;
        wait_q(4);
        n_checks += 7;
        if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL reset_sda_oe: got %b, required 0", sda_oe); end
        if (wr_stb !== 1'b0) begin n_errors++; $display("FAIL reset_wr_stb: got %b, required 0", wr_stb); end
        if (rd_stb !== 1'b0) begin n_errors++; $display("FAIL reset_rd_stb: got %b, required 0", rd_stb); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (wr_addr !== 8'h00) begin n_errors++; $display("FAIL reset_wr_addr: got %h, required 00", wr_addr); end
        if (wr_data !== 8'h00) begin n_errors++; $display("FAIL reset_wr_data: got %h, required 00", wr_data); end
        if (debug_out !== 32'h0) begin n_errors++; $display("FAIL reset_debug: got %h, required 0", debug_out); end
    endtask
    task automatic test_write3;
        logic a1, a2, a3;
        bus_start();
        send_byte(8'h42, a1);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL w3_busy_set: got %b, required 1", busy); end
        send_byte(8'h12, a2);
        exp_q.push_back({8'h12, 8'h80});
        model[8'h12] = 8'h80;
        send_byte(8'h80, a3);
        bus_stop();
        n_checks += 6;
        if (a1 !== EXP_ACK) begin n_errors++; $display("FAIL w3_x_id: got %b, required %b", a1, EXP_ACK); end
        if (a2 !== EXP_ACK) begin n_errors++; $display("FAIL w3_x_sub: got %b, required %b", a2, EXP_ACK); end
        if (a3 !== EXP_ACK) begin n_errors++; $display("FAIL w3_x_data: got %b, required %b", a3, EXP_ACK); end
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL w3_strobe_missing: got %0d pending, required 0", exp_q.size()); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL w3_busy_clear: got %b, required 0", busy); end
        if (debug_out !== 32'h12800001) begin n_errors++; $display("FAIL w3_debug: got %h, required 12800001", debug_out); end
    endtask
    task automatic test_read;
        logic a, a1, na;
        logic [7:0] v, e;
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'h12, a);
        bus_stop();
        rd_cnt = 0;
        e = model[8'h12];
        bus_start();
        send_byte(8'h43, a1);
        read_byte(v, na);
        bus_stop();
        for (int i = 7; i >= 0; i--) begin
            n_checks++;
            if (v[i] !== e[i]) begin n_errors++; $display("FAIL rd_bit%0d: got %b, required %b", i, v[i], e[i]); end
        end
        n_checks += 3;
        if (a1 !== EXP_ACK) begin n_errors++; $display("FAIL rd_x_id: got %b, required %b", a1, EXP_ACK); end
        if (rd_cnt != 1) begin n_errors++; $display("FAIL rd_stb_count: got %0d, required 1", rd_cnt); end
        if (na !== 1'b0) begin n_errors++; $display("FAIL rd_na_release: got %b, required 0", na); end
    endtask
    task automatic test_bad_id;
        logic a;
        m_scl = 1'b1; m_sda = 1'b1; wait_q(Q);
        seen_oe = 1'b0; seen_busy = 1'b0;
        bus_start();
        send_byte(8'h60, a);
        send_byte(8'h12, a);
        send_byte(8'h55, a);
        bus_stop();
        n_checks += 3;
        if (seen_busy !== 1'b0) begin n_errors++; $display("FAIL bad_id_busy: got %b, required 0", seen_busy); end
        if (seen_oe !== 1'b0) begin n_errors++; $display("FAIL bad_id_sda_oe: got %b, required 0", seen_oe); end
        if (debug_out[15:0] !== 16'd1) begin n_errors++; $display("FAIL bad_id_count: got %0d, required 1", debug_out[15:0]); end
    endtask
    task automatic test_abort;
        logic a, l, o;
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'h3A, a);
        for (int i = 0; i < 5; i++) send_bit(1'b0, l, o);
        bus_stop();
        n_checks++;
        if (debug_out !== 32'h12800001) begin n_errors++; $display("FAIL abort_no_commit: got %h, required 12800001", debug_out); end
        bus_start();
        send_byte(8'h42, a);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_restart_busy: got %b, required 1", busy); end
        send_byte(8'h3A, a);
        exp_q.push_back({8'h3A, 8'h04});
        model[8'h3A] = 8'h04;
        send_byte(8'h04, a);
        bus_stop();
        n_checks += 2;
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL abort_strobe_missing: got %0d pending, required 0", exp_q.size()); end
        if (debug_out !== 32'h3A040002) begin n_errors++; $display("FAIL abort_debug: got %h, required 3a040002", debug_out); end
    endtask
    task automatic test_reset_mid_read;
        logic a, l, o, na;
        logic [7:0] v;
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'h12, a);
        bus_stop();
        bus_start();
        send_byte(8'h43, a);
        send_bit(1'b1, l, o);
        m_sda = 1'b1;
        wait_q(Q);
        n_checks++;
        if (sda_oe !== 1'b1) begin n_errors++; $display("FAIL rmr_driving: got %b, required 1", sda_oe); end
        rst = 1'b1; m_scl = 1'b1;
        tick();
        n_checks += 3;
        if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL rmr_sda_oe: got %b, required 0", sda_oe); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rmr_busy: got %b, required 0", busy); end
        if ({debug_out, wr_addr, wr_data} !== 48'h0) begin n_errors++; $display("FAIL rmr_outputs: got %h, required 0", {debug_out, wr_addr, wr_data}); end
        wait_q(3);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        wait_q(Q);
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'h12, a);
        bus_stop();
        rd_cnt = 0;
        bus_start();
        send_byte(8'h43, a);
        read_byte(v, na);
        bus_stop();
        n_checks += 2;
        if (v !== model[8'h12]) begin n_errors++; $display("FAIL rmr_readback: got %h, required %h", v, model[8'h12]); end
        if (rd_cnt != 1) begin n_errors++; $display("FAIL rmr_rd_stb: got %0d, required 1", rd_cnt); end
    endtask
    initial begin
        test_reset();
        test_write3();
        test_read();
        test_bad_id();
        test_abort();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
